// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_AW = 8;
    localparam int unsigned MEM_DW = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    // Outstanding read: one read may be in flight in the memory pipeline.
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_owner_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_rsp_track.sv
// Tracks which port owns the read currently in the memory pipeline and
// raises that port's response valid in the cycle the read data appears.
module mem_arb_rsp_track
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     rd_accept,
    input  port_id_t rd_port,
    output logic     f_rsp_valid,
    output logic     d_rsp_valid
);

    rd_owner_t owner_q;

    // Capture the owner of the read accepted this cycle; reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q.valid <= 1'b0;
            owner_q.port  <= PORT_F;
        end else begin
            owner_q.valid <= rd_accept;
            owner_q.port  <= rd_port;
        end
    end

    // Only one owner exists, so the two valids are mutually exclusive.
    assign f_rsp_valid = owner_q.valid && (owner_q.port == PORT_F);
    assign d_rsp_valid = owner_q.valid && (owner_q.port == PORT_D);

endmodule : mem_arb_rsp_track

// File: rtl/mem_arbiter.sv
// Two-port arbiter (fetch F read-only, data D read/write) for a single-port
// synchronous 256x8 data memory, with a D lock for read-modify-write.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects alternating priority on
// contention; when undefined, D has fixed priority over F.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req_valid,
    input  logic [AW-1:0] f_req_addr,
    output logic          f_req_ready,
    output logic          f_rsp_valid,
    input  logic          d_req_valid,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    input  logic          d_lock,
    output logic          d_req_ready,
    output logic          d_rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          memory_w_en,
    output logic          memory_r_en,
    input  logic [DW-1:0] mem_out,
    output logic          locked
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       win_valid;
    port_id_t   win_port;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;
    logic contended;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who won the last contended ARB cycle; reset favours F first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d <= 1'b1;
        end else if (contended) begin
            last_d <= (win_port == PORT_D);
        end
    end
`endif

    // Winner selection, readies and next state.
    always_comb begin
        state_d     = state_q;
        win_valid   = 1'b0;
        win_port    = PORT_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        contended   = 1'b0;
`endif
        case (state_q)
            ARB: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                contended = f_req_valid && d_req_valid;
                if (contended) begin
                    win_valid = 1'b1;
                    win_port  = last_d ? PORT_F : PORT_D;
                end else if (f_req_valid) begin
                    win_valid = 1'b1;
                    win_port  = PORT_F;
                end else if (d_req_valid) begin
                    win_valid = 1'b1;
                    win_port  = PORT_D;
                end
`else
                if (d_req_valid) begin
                    win_valid = 1'b1;
                    win_port  = PORT_D;
                end else if (f_req_valid) begin
                    win_valid = 1'b1;
                    win_port  = PORT_F;
                end
`endif
                if (win_valid && (win_port == PORT_D) && d_lock) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                win_valid = d_req_valid;
                win_port  = PORT_D;
                if (!d_lock) begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    assign f_req_ready = win_valid && (win_port == PORT_F);
    assign d_req_ready = win_valid && (win_port == PORT_D);

    // Memory drive follows the winner; idle cycles park on the D fields.
    assign mem_addr    = (f_req_ready) ? f_req_addr : d_req_addr;
    assign mem_in      = d_req_wdata;
    assign memory_r_en = f_req_ready || (d_req_ready && !d_req_we);
    assign memory_w_en = d_req_ready && d_req_we;

    assign rsp_rdata   = mem_out;
    assign locked      = (state_q == LOCKED);

    mem_arb_rsp_track u_rsp_track (
        .clk         (clk),
        .reset       (reset),
        .rd_accept   (memory_r_en),
        .rd_port     (win_port),
        .f_rsp_valid (f_rsp_valid),
        .d_rsp_valid (d_rsp_valid)
    );

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 synchronous memory.
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          reset;
    logic          f_req_valid;
    logic [AW-1:0] f_req_addr;
    logic          f_req_ready;
    logic          f_rsp_valid;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_lock;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic          memory_w_en;
    logic          memory_r_en;
    logic [DW-1:0] mem_out;
    logic          locked;

    logic [DW-1:0] mem [256];

    int n_vec;
    int n_err;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_rsp_valid (f_rsp_valid),
        .d_req_valid (d_req_valid),
        .d_req_we    (d_req_we),
        .d_req_addr  (d_req_addr),
        .d_req_wdata (d_req_wdata),
        .d_lock      (d_lock),
        .d_req_ready (d_req_ready),
        .d_rsp_valid (d_rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_addr    (mem_addr),
        .mem_in      (mem_in),
        .memory_w_en (memory_w_en),
        .memory_r_en (memory_r_en),
        .mem_out     (mem_out),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory with registered read data.
    always @(posedge clk) begin
        if (memory_w_en) mem[mem_addr] <= mem_in;
        if (memory_r_en) mem_out <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req_valid = 1'b0;
        f_req_addr  = '0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = '0;
        d_req_wdata = '0;
        d_lock      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic d_write(input logic [7:0] a, input logic [7:0] wd);
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = a;
        d_req_wdata = wd;
        @(negedge clk);
        check("dwr_ready", 16'(d_req_ready), 16'd1);
        tick();
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
    endtask

    logic [7:0] stream_exp [4];
    logic       f_win;
    logic       prev_f_win;

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_out = 8'h00;
        idle_inputs();
        reset = 1'b1;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_f_rsp", 16'(f_rsp_valid), 16'd0);
        check("rst_d_rsp", 16'(d_rsp_valid), 16'd0);
        check("rst_locked", 16'(locked), 16'd0);
        check("rst_rd_en", 16'(memory_r_en), 16'd0);
        check("rst_wr_en", 16'(memory_w_en), 16'd0);
        tick();
        reset = 1'b0;

        // D write 0x3C -> 0x10, then read it back
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 8'h10; d_req_wdata = 8'h3C;
        @(negedge clk);
        check("wr_ready", 16'(d_req_ready), 16'd1);
        check("wr_wen", 16'(memory_w_en), 16'd1);
        check("wr_ren", 16'(memory_r_en), 16'd0);
        check("wr_addr", 16'(mem_addr), 16'h10);
        tick();
        d_req_we = 1'b0;
        @(negedge clk);
        check("rd_ready", 16'(d_req_ready), 16'd1);
        check("rd_ren", 16'(memory_r_en), 16'd1);
        check("wr_no_rsp", 16'(d_rsp_valid), 16'd0);
        tick();
        d_req_valid = 1'b0;
        @(negedge clk);
        check("rd_d_rsp", 16'(d_rsp_valid), 16'd1);
        check("rd_f_rsp", 16'(f_rsp_valid), 16'd0);
        check("rd_data", 16'(rsp_rdata), 16'h3C);
        tick();

        // Preload for later tests
        d_write(8'h11, 8'hA1);
        d_write(8'h12, 8'hA2);
        d_write(8'h13, 8'hA3);
        d_write(8'h00, 8'h5A);
        d_write(8'h20, 8'h77);

        // Streaming F reads 0x10..0x13
        stream_exp[0] = 8'h3C; stream_exp[1] = 8'hA1;
        stream_exp[2] = 8'hA2; stream_exp[3] = 8'hA3;
        for (int k = 0; k < 4; k++) begin
            f_req_valid = 1'b1;
            f_req_addr  = 8'(8'h10 + k);
            @(negedge clk);
            check("str_ready", 16'(f_req_ready), 16'd1);
            check("str_f_rsp", 16'(f_rsp_valid), (k > 0) ? 16'd1 : 16'd0);
            if (k > 0) check("str_data", 16'(rsp_rdata), 16'(stream_exp[k-1]));
            tick();
        end
        f_req_valid = 1'b0;
        @(negedge clk);
        check("str_f_rsp_last", 16'(f_rsp_valid), 16'd1);
        check("str_data_last", 16'(rsp_rdata), 16'hA3);
        tick();
        @(negedge clk);
        check("str_done", 16'(f_rsp_valid), 16'd0);

        // Contention: F reads 0x00 (0x5A), D reads 0x10 (0x3C)
        do_reset();
        prev_f_win = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 8'h00;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h10;
        for (int c = 0; c < 4; c++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            f_win = (c % 2 == 0);
`else
            f_win = 1'b0;
`endif
            @(negedge clk);
            check("cnt_f_ready", 16'(f_req_ready), 16'(f_win));
            check("cnt_d_ready", 16'(d_req_ready), 16'(!f_win));
            if (c > 0) begin
                check("cnt_f_rsp", 16'(f_rsp_valid), 16'(prev_f_win));
                check("cnt_d_rsp", 16'(d_rsp_valid), 16'(!prev_f_win));
                check("cnt_data", 16'(rsp_rdata), prev_f_win ? 16'h5A : 16'h3C);
            end
            prev_f_win = f_win;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("cnt_f_rsp_last", 16'(f_rsp_valid), 16'(prev_f_win));
        check("cnt_d_rsp_last", 16'(d_rsp_valid), 16'(!prev_f_win));
        tick();

        // Lock: read 0x20, write 0x21, release with a read of 0x11
        do_reset();
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h20; d_lock = 1'b1;
        @(negedge clk);
        check("lk_a_dready", 16'(d_req_ready), 16'd1);
        check("lk_a_locked", 16'(locked), 16'd0);
        tick();
        d_req_we = 1'b1; d_req_wdata = 8'h21;
        f_req_valid = 1'b1; f_req_addr = 8'h20;
        @(negedge clk);
        check("lk_b_locked", 16'(locked), 16'd1);
        check("lk_b_fready", 16'(f_req_ready), 16'd0);
        check("lk_b_dready", 16'(d_req_ready), 16'd1);
        check("lk_b_wen", 16'(memory_w_en), 16'd1);
        check("lk_b_d_rsp", 16'(d_rsp_valid), 16'd1);
        check("lk_b_data", 16'(rsp_rdata), 16'h77);
        tick();
        d_req_we = 1'b0; d_req_addr = 8'h11; d_lock = 1'b0;
        @(negedge clk);
        check("lk_c_locked", 16'(locked), 16'd1);
        check("lk_c_fready", 16'(f_req_ready), 16'd0);
        check("lk_c_dready", 16'(d_req_ready), 16'd1);
        check("lk_c_d_rsp", 16'(d_rsp_valid), 16'd0);
        tick();
        d_req_valid = 1'b0;
        @(negedge clk);
        check("lk_d_locked", 16'(locked), 16'd0);
        check("lk_d_fready", 16'(f_req_ready), 16'd1);
        check("lk_d_d_rsp", 16'(d_rsp_valid), 16'd1);
        check("lk_d_data", 16'(rsp_rdata), 16'hA1);
        tick();
        f_req_valid = 1'b0;
        @(negedge clk);
        check("lk_e_f_rsp", 16'(f_rsp_valid), 16'd1);
        check("lk_e_data", 16'(rsp_rdata), 16'h21);
        tick();

        // d_lock alone in ARB must not lock
        d_lock = 1'b1;
        tick();
        @(negedge clk);
        check("lk_nolock", 16'(locked), 16'd0);
        tick();
        d_lock = 1'b0;

        // Reset while locked, then an F read accepted during reset
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h20; d_lock = 1'b1;
        tick();
        d_req_valid = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 8'h10;
        reset = 1'b1;
        @(negedge clk);
        check("rr_locked", 16'(locked), 16'd1);
        check("rr_fready0", 16'(f_req_ready), 16'd0);
        check("rr_d_rsp", 16'(d_rsp_valid), 16'd1);
        check("rr_d_data", 16'(rsp_rdata), 16'h21);
        tick();
        @(negedge clk);
        check("rr_unlocked", 16'(locked), 16'd0);
        check("rr_fready1", 16'(f_req_ready), 16'd1);
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rr_no_f_rsp", 16'(f_rsp_valid), 16'd0);
        check("rr_no_d_rsp", 16'(d_rsp_valid), 16'd0);
        check("rr_locked_end", 16'(locked), 16'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Responses are exclusive at every sample point.
    always @(negedge clk) begin
        if (f_rsp_valid && d_rsp_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_excl: got both valids 1 expected at most one (t=%0t)", $time);
        end
    end

endmodule : tb_mem_arbiter
